// File: rtl/matrix_cmd_sched.sv
// Command scheduler for the matrix unit: arbitrates two requesters round-robin,
// holds the granted command stable and supervises the go/busy handshake.
module matrix_cmd_sched #(
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned START_WIN = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [150:0] cmd_a,
    input  logic [150:0] cmd_b,
    output logic         ack_a,
    output logic         ack_b,
    output logic         done_a,
    output logic         done_b,
    output logic [1:0]   status,
    output logic [4:0]   result_obj,
    output logic         go,
    output logic [3:0]   gmt_op,
    output logic [3:0]   gmt_code,
    output logic [4:0]   obj_num,
    output logic [1:0]   obj_type,
    output logic [7:0]   obj_color,
    output logic [15:0]  v0,
    output logic [15:0]  v1,
    output logic [15:0]  v2,
    output logic [15:0]  v3,
    output logic [15:0]  v4,
    output logic [15:0]  v5,
    output logic [15:0]  v6,
    output logic [15:0]  v7,
    input  logic         busy,
    input  logic [4:0]   lst_stored_obj,
    input  logic         obj_mem_full,
    output logic         sched_busy
);

    typedef enum logic [2:0] {StIdle, StIssue, StStart, StRun, StDone} state_e;

    localparam logic [9:0] StartLast   = 10'(START_WIN - 1);
    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT - 1);

    state_e       state_q;
    logic [150:0] cmd_q;
    logic         owner_b_q;
    logic         last_b_q;
    logic [9:0]   start_cnt_q;
    logic [9:0]   run_cnt_q;

    logic         grant_b;
    logic [150:0] cmd_sel;
    logic         reject;

    // B wins only when alone or when A was served last.
    assign grant_b = req_b && (!req_a || !last_b_q);
    assign cmd_sel = grant_b ? cmd_b : cmd_a;
    assign reject  = (cmd_sel[150:147] == 4'd0) && obj_mem_full;

    assign gmt_op     = cmd_q[150:147];
    assign gmt_code   = cmd_q[146:143];
    assign obj_num    = cmd_q[142:138];
    assign obj_type   = cmd_q[137:136];
    assign obj_color  = cmd_q[135:128];
    assign v7         = cmd_q[127:112];
    assign v6         = cmd_q[111:96];
    assign v5         = cmd_q[95:80];
    assign v4         = cmd_q[79:64];
    assign v3         = cmd_q[63:48];
    assign v2         = cmd_q[47:32];
    assign v1         = cmd_q[31:16];
    assign v0         = cmd_q[15:0];
    assign sched_busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            owner_b_q   <= 1'b0;
            last_b_q    <= 1'b1;
            start_cnt_q <= '0;
            run_cnt_q   <= '0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            go          <= 1'b0;
            status      <= 2'd0;
            result_obj  <= 5'd0;
        end else begin
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            go     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_a || req_b) begin
                        cmd_q     <= cmd_sel;
                        owner_b_q <= grant_b;
                        ack_a     <= !grant_b;
                        ack_b     <= grant_b;
                        if (reject) begin
                            status  <= 2'd1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    go          <= 1'b1;
                    start_cnt_q <= '0;
                    state_q     <= StStart;
                end
                StStart: begin
                    if (busy) begin
                        run_cnt_q <= '0;
                        state_q   <= StRun;
                    end else if (start_cnt_q >= StartLast) begin
                        status  <= 2'd3;
                        state_q <= StDone;
                    end else if (start_cnt_q != 10'h3ff) begin
                        start_cnt_q <= start_cnt_q + 10'd1;
                    end
                end
                StRun: begin
                    if (!busy) begin
                        status  <= 2'd0;
                        state_q <= StDone;
                    end else if (run_cnt_q >= TimeoutLast) begin
                        status  <= 2'd2;
                        state_q <= StDone;
                    end else if (run_cnt_q != 10'h3ff) begin
                        run_cnt_q <= run_cnt_q + 10'd1;
                    end
                end
                StDone: begin
                    done_a     <= !owner_b_q;
                    done_b     <= owner_b_q;
                    result_obj <= lst_stored_obj;
                    last_b_q   <= owner_b_q;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_cmd_sched.sv
// Directed bench for matrix_cmd_sched: handshake timing, arbitration, reject,
// no-start, timeout, mid-run reset and command hold.
module tb_matrix_cmd_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_a, req_b;
    logic [150:0] cmd_a, cmd_b;
    logic         ack_a, ack_b, done_a, done_b, go, sched_busy;
    logic [1:0]   status;
    logic [4:0]   result_obj;
    logic [3:0]   gmt_op, gmt_code;
    logic [4:0]   obj_num;
    logic [1:0]   obj_type;
    logic [7:0]   obj_color;
    logic [15:0]  v0, v1, v2, v3, v4, v5, v6, v7;
    logic         busy;
    logic [4:0]   lst_stored_obj;
    logic         obj_mem_full;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] VecA = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [127:0] VecB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    matrix_cmd_sched dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b), .status(status),
        .result_obj(result_obj), .go(go), .gmt_op(gmt_op), .gmt_code(gmt_code),
        .obj_num(obj_num), .obj_type(obj_type), .obj_color(obj_color),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
        .busy(busy), .lst_stored_obj(lst_stored_obj), .obj_mem_full(obj_mem_full),
        .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [150:0] got, input logic [150:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(done_a || done_b) && n < max);
    endtask

    function automatic logic [150:0] obs();
        return {gmt_op, gmt_code, obj_num, obj_type, obj_color, v7, v6, v5, v4, v3, v2, v1, v0};
    endfunction

    function automatic logic [150:0] ctl();
        return 151'({go, ack_a, ack_b, done_a, done_b, sched_busy, status, result_obj});
    endfunction

    logic [150:0] exp_cmd;
    int           n;

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; cmd_a = '0; cmd_b = '0;
        busy = 1'b0; lst_stored_obj = 5'd0; obj_mem_full = 1'b0;
        repeat (2) tick();
        check("rst_ctl", ctl(), '0);
        check("rst_cmd", obs(), '0);
        rst = 1'b0;
        tick();

        // Translate on A: ack, go next cycle, fields held while cmd_a toggles.
        exp_cmd = {4'd3, 4'd5, 5'd7, 2'd1, 8'ha5, VecA};
        cmd_a = exp_cmd;
        req_a = 1'b1;
        tick();
        check("t31_ack", {ack_a, ack_b, go}, 3'b100);
        check("t31_sbusy", sched_busy, 1'b1);
        check("t31_cmd", obs(), exp_cmd);
        req_a = 1'b0;
        cmd_a = ~cmd_a;
        tick();
        check("t31_go", {ack_a, go}, 2'b01);
        busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_a = ~cmd_a;
            tick();
            check("t31_hold", obs(), exp_cmd);
            check("t31_quiet", {go, done_a, done_b}, 3'b000);
        end
        busy = 1'b0;
        lst_stored_obj = 5'd17;
        wait_done(20, n);
        check("t31_lat", n, 2);
        check("t31_done", {done_a, done_b, status}, {2'b10, 2'd0});
        check("t31_res", result_obj, 5'd17);
        check("t31_hold_done", obs(), exp_cmd);
        tick();
        check("t31_pulse", {done_a, done_b}, 2'b00);

        // Create on B with memory full: rejected, no go.
        exp_cmd = {4'd0, 4'd1, 5'd3, 2'd2, 8'h11, VecB};
        cmd_b = exp_cmd;
        obj_mem_full = 1'b1;
        lst_stored_obj = 5'd21;
        req_b = 1'b1;
        tick();
        check("t33_ack", {ack_a, ack_b, go}, 3'b010);
        check("t33_sbusy", sched_busy, 1'b1);
        req_b = 1'b0;
        tick();
        check("t33_done", {done_a, done_b, go, status}, 5'b01001);
        check("t33_res", result_obj, 5'd21);
        check("t33_cmd", obs(), exp_cmd);

        // Both requesting: grants alternate A,B,A,B.
        cmd_a = {4'd0, 4'd2, 5'd1, 2'd0, 8'h22, VecA};
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] w;
            w = (i % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            check("t32_ack", {ack_a, ack_b}, w);
            if (w[1]) req_a = 1'b0; else req_b = 1'b0;
            tick();
            check("t32_done", {done_a, done_b, ack_a, ack_b}, {w, 2'b00});
            if (i < 3) begin
                if (w[1]) req_a = 1'b1; else req_b = 1'b1;
            end else begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
        obj_mem_full = 1'b0;
        tick();

        // Reset during RUN, then restart with last-grant back at B.
        exp_cmd = {4'd3, 4'd2, 5'd4, 2'd3, 8'h5a, VecB};
        cmd_a = exp_cmd;
        req_a = 1'b1;
        tick();
        check("t35_ack", {ack_a, ack_b}, 2'b10);
        req_a = 1'b0;
        tick();
        check("t35_go", go, 1'b1);
        busy = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("t35_rst_ctl", ctl(), '0);
        check("t35_rst_cmd", obs(), '0);
        rst = 1'b0;
        exp_cmd = {4'd4, 4'd9, 5'd30, 2'd1, 8'hc3, VecA};
        cmd_a = exp_cmd;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        check("t35_regrant", {ack_a, ack_b}, 2'b10);
        check("t35_cmd", obs(), exp_cmd);
        busy = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        check("t34_go", {go, ack_b}, 2'b10);

        // Busy never rises: no-start after START_WIN cycles.
        wait_done(10, n);
        check("t34_ns_lat", n, 4);
        check("t34_ns_done", {done_a, done_b, status}, {2'b10, 2'd3});
        tick();
        check("t25_drop", {ack_a, ack_b, sched_busy}, 3'b000);

        // Busy stuck high: timeout after TIMEOUT cycles in RUN.
        req_a = 1'b1;
        tick();
        check("t34_to_ack", ack_a, 1'b1);
        req_a = 1'b0;
        tick();
        check("t34_to_go", go, 1'b1);
        busy = 1'b1;
        wait_done(1100, n);
        check("t34_to_lat", n, 1025);
        check("t34_to_done", {done_a, done_b, status}, {2'b10, 2'd2});
        busy = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
